// File: rtl/bfu_pkg.sv
// bfu_pkg: shared constants, the per-beat mode tag and Montgomery helpers
// for the bfu_lanes butterfly array.
// Optional feature macro: BFU_CANON_EN (adds stage S5 mapping outputs to [0,q)).
package bfu_pkg;

    localparam int WORD_W = 32;

    localparam logic signed [31:0] KYBER_Q        = 32'sd3329;
    localparam logic signed [31:0] KYBER_QINV     = -32'sd3327;
    localparam logic signed [31:0] DILITHIUM_Q    = 32'sd8380417;
    localparam logic signed [31:0] DILITHIUM_QINV = 32'sd58728449;

`ifdef BFU_CANON_EN
    localparam int NSTAGE = 6;
`else
    localparam int NSTAGE = 5;
`endif
    // Tags are needed by every stage except the last one.
    localparam int NTAG = NSTAGE - 1;

    typedef struct packed {
        logic algo;  // 0 = Kyber, 1 = Dilithium
        logic intt;  // 0 = CT butterfly, 1 = GS butterfly
        logic skip;  // pass a/b through unchanged
    } bfu_tag_t;

    function automatic logic signed [31:0] mod_q(input logic algo);
        if (algo) begin
            return DILITHIUM_Q;
        end else begin
            return KYBER_Q;
        end
    endfunction

    // First Montgomery step: m = x * QINV mod R, taken as a signed residue.
    function automatic logic signed [31:0] mont_qinv_m(input logic signed [63:0] x,
                                                       input logic               algo);
        if (algo) begin
            return 32'(x * 64'(DILITHIUM_QINV));
        end else begin
            return 32'(signed'(16'(x * 64'(KYBER_QINV))));
        end
    endfunction

    // Second Montgomery step: (x - m*q) / R, exact because x - m*q is a multiple of R.
    function automatic logic signed [31:0] mont_fold(input logic signed [63:0] x,
                                                     input logic signed [31:0] m,
                                                     input logic               algo);
        logic signed [63:0] diff;
        diff = x - 64'(m) * 64'(mod_q(algo));
        if (algo) begin
            return 32'(diff >>> 32);
        end else begin
            return 32'(diff >>> 16);
        end
    endfunction

    // Complete single-cycle Montgomery reduction of a 64-bit signed product.
    function automatic logic signed [31:0] mont_reduce(input logic signed [63:0] prod64,
                                                       input logic               algo);
        return mont_fold(prod64, mont_qinv_m(prod64, algo), algo);
    endfunction

    // Map a value in (-2q,2q) into [0,q).
    function automatic logic signed [31:0] canon_map(input logic signed [31:0] r,
                                                     input logic               algo);
        logic signed [31:0] q;
        logic signed [31:0] v;
        q = mod_q(algo);
        if (r < 32'sd0) begin
            v = r + 32'sd2 * q;
        end else begin
            v = r;
        end
        if (v >= q) begin
            v = v - q;
        end else begin
            v = v;
        end
        return v;
    endfunction

endpackage

// File: rtl/bfu_lane.sv
// bfu_lane: one butterfly lane. Holds only data registers; valid bits and
// mode tags come from the shared pipeline in bfu_lanes, and every register
// moves only when i_adv is high.
// Optional feature macro: BFU_CANON_EN (adds output stage S5).
module bfu_lane
    import bfu_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_adv,
    input  bfu_tag_t [NTAG-1:0]      i_tag,
    input  logic signed [WORD_W-1:0] i_a,
    input  logic signed [WORD_W-1:0] i_b,
    input  logic signed [WORD_W-1:0] i_tw,
    output logic signed [WORD_W-1:0] o_a,
    output logic signed [WORD_W-1:0] o_b
);

    // S0 input registers
    logic signed [31:0] a0_q, a0_d, b0_q, b0_d, tw0_q, tw0_d;
    // S1 product, additive operand (a or a+b) and raw b for skip beats
    logic signed [63:0] p1_q, p1_d;
    logic signed [31:0] x1_q, x1_d, y1_q, y1_d;
    // S2 product and QINV factor
    logic signed [63:0] p2_q, p2_d;
    logic signed [31:0] m2_q, m2_d, x2_q, x2_d, y2_q, y2_d;
    // S3 reduced twiddle product
    logic signed [31:0] r3_q, r3_d, x3_q, x3_d, y3_q, y3_d;
    // S4 butterfly results
    logic signed [31:0] oa4_q, oa4_d, ob4_q, ob4_d;
`ifdef BFU_CANON_EN
    // S5 canonical results
    logic signed [31:0] oa5_q, oa5_d, ob5_q, ob5_d;
`endif

    logic signed [31:0] q0_s, sum_s, sum_c1_s, sum_c2_s, mul_in_s;

    // Only algo matters in the reduction stages and only intt/skip at the butterfly stage.
    logic unused_tag_s;
`ifdef BFU_CANON_EN
    assign unused_tag_s = ^{i_tag[1].intt, i_tag[1].skip, i_tag[2].intt, i_tag[2].skip,
                            i_tag[3].algo, i_tag[4].intt};
`else
    assign unused_tag_s = ^{i_tag[1].intt, i_tag[1].skip, i_tag[2].intt, i_tag[2].skip,
                            i_tag[3].algo};
`endif

    // Next-state datapath of every stage, each using the tag of the beat it consumes.
    always_comb begin
        a0_d  = i_a;
        b0_d  = i_b;
        tw0_d = i_tw;

        q0_s  = mod_q(i_tag[0].algo);
        sum_s = a0_q + b0_q;
        // Kyber INTT keeps a+b inside (-q,q) with two conditional corrections.
        if (!i_tag[0].algo && (sum_s >= q0_s)) begin
            sum_c1_s = sum_s - q0_s;
        end else begin
            sum_c1_s = sum_s;
        end
        if (!i_tag[0].algo && (sum_c1_s <= -q0_s)) begin
            sum_c2_s = sum_c1_s + q0_s;
        end else begin
            sum_c2_s = sum_c1_s;
        end
        if (i_tag[0].intt) begin
            mul_in_s = b0_q - a0_q;
        end else begin
            mul_in_s = b0_q;
        end
        p1_d = 64'(mul_in_s) * 64'(tw0_q);
        if (i_tag[0].intt && !i_tag[0].skip) begin
            x1_d = sum_c2_s;
        end else begin
            x1_d = a0_q;
        end
        y1_d = b0_q;

        p2_d = p1_q;
        m2_d = mont_qinv_m(p1_q, i_tag[1].algo);
        x2_d = x1_q;
        y2_d = y1_q;

        r3_d = mont_fold(p2_q, m2_q, i_tag[2].algo);
        x3_d = x2_q;
        y3_d = y2_q;

        if (i_tag[3].skip) begin
            oa4_d = x3_q;
            ob4_d = y3_q;
        end else if (i_tag[3].intt) begin
            oa4_d = x3_q;
            ob4_d = r3_q;
        end else begin
            oa4_d = x3_q + r3_q;
            ob4_d = x3_q - r3_q;
        end

`ifdef BFU_CANON_EN
        if (i_tag[4].skip) begin
            oa5_d = oa4_q;
            ob5_d = ob4_q;
        end else begin
            oa5_d = canon_map(oa4_q, i_tag[4].algo);
            ob5_d = canon_map(ob4_q, i_tag[4].algo);
        end
`endif
    end

    // Stage registers: cleared by reset, frozen as a whole while the pipeline stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a0_q  <= '0;  b0_q  <= '0;  tw0_q <= '0;
            p1_q  <= '0;  x1_q  <= '0;  y1_q  <= '0;
            p2_q  <= '0;  m2_q  <= '0;  x2_q  <= '0;  y2_q <= '0;
            r3_q  <= '0;  x3_q  <= '0;  y3_q  <= '0;
            oa4_q <= '0;  ob4_q <= '0;
`ifdef BFU_CANON_EN
            oa5_q <= '0;  ob5_q <= '0;
`endif
        end else if (i_adv) begin
            a0_q  <= a0_d;  b0_q  <= b0_d;  tw0_q <= tw0_d;
            p1_q  <= p1_d;  x1_q  <= x1_d;  y1_q  <= y1_d;
            p2_q  <= p2_d;  m2_q  <= m2_d;  x2_q  <= x2_d;  y2_q <= y2_d;
            r3_q  <= r3_d;  x3_q  <= x3_d;  y3_q  <= y3_d;
            oa4_q <= oa4_d; ob4_q <= ob4_d;
`ifdef BFU_CANON_EN
            oa5_q <= oa5_d; ob5_q <= ob5_d;
`endif
        end
    end

`ifdef BFU_CANON_EN
    assign o_a = oa5_q;
    assign o_b = ob5_q;
`else
    assign o_a = oa4_q;
    assign o_b = ob4_q;
`endif

endmodule

// File: rtl/bfu_lanes.sv
// bfu_lanes: LANES parallel NTT/INTT butterflies with Montgomery reduction.
// Owns the per-stage valid bits, the mode-tag pipeline and the valid/ready
// handshake; all lanes advance together on one shared advance signal.
// Optional feature macro: BFU_CANON_EN (outputs mapped to [0,q), latency 6).
module bfu_lanes
    import bfu_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic                           i_algo,
    input  logic                           i_intt,
    input  logic                           i_skip,
    input  logic signed [LANES*WORD_W-1:0] i_a,
    input  logic signed [LANES*WORD_W-1:0] i_b,
    input  logic signed [LANES*WORD_W-1:0] i_twiddle,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic signed [LANES*WORD_W-1:0] o_a,
    output logic signed [LANES*WORD_W-1:0] o_b
);

    logic [NSTAGE-1:0]  valid_q, valid_d;
    bfu_tag_t [NTAG-1:0] tag_q, tag_d;
    bfu_tag_t           in_tag_s;
    logic               adv_s;

    // Shared advance, and the shift of valid bits and mode tags one stage per advance.
    always_comb begin
        adv_s         = !valid_q[NSTAGE-1] || i_ready;
        in_tag_s.algo = i_algo;
        in_tag_s.intt = i_intt;
        in_tag_s.skip = i_skip;
        valid_d       = valid_q;
        tag_d         = tag_q;
        if (adv_s) begin
            for (int i = NSTAGE - 1; i > 0; i--) begin
                valid_d[i] = valid_q[i-1];
            end
            valid_d[0] = i_valid;
            for (int i = NTAG - 1; i > 0; i--) begin
                tag_d[i] = tag_q[i-1];
            end
            tag_d[0] = in_tag_s;
        end else begin
            valid_d = valid_q;
            tag_d   = tag_q;
        end
    end

    // Valid and tag pipeline registers; reset discards every beat in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign o_ready = adv_s;
    assign o_valid = valid_q[NSTAGE-1];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        bfu_lane u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_adv   (adv_s),
            .i_tag   (tag_q),
            .i_a     (i_a[k*WORD_W +: WORD_W]),
            .i_b     (i_b[k*WORD_W +: WORD_W]),
            .i_tw    (i_twiddle[k*WORD_W +: WORD_W]),
            .o_a     (o_a[k*WORD_W +: WORD_W]),
            .o_b     (o_b[k*WORD_W +: WORD_W])
        );
    end

endmodule

// File: tb/tb_bfu_lanes.sv
// tb_bfu_lanes: directed and randomized bench for bfu_lanes with a
// scoreboard fed by an arithmetic reference model.
// Honours BFU_CANON_EN (latency 6, outputs expected in [0,q)).
module tb_bfu_lanes;

    localparam int LANES = 4;
    localparam int W     = LANES * 32;
`ifdef BFU_CANON_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                i_valid = 1'b0;
    logic                i_ready = 1'b0;
    logic                i_algo = 1'b0;
    logic                i_intt = 1'b0;
    logic                i_skip = 1'b0;
    logic signed [W-1:0] i_a = '0;
    logic signed [W-1:0] i_b = '0;
    logic signed [W-1:0] i_twiddle = '0;
    logic                o_ready;
    logic                o_valid;
    logic signed [W-1:0] o_a;
    logic signed [W-1:0] o_b;

    typedef struct packed {
        logic [W-1:0] ea;
        logic [W-1:0] eb;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    bfu_lanes #(.LANES(LANES)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_algo    (i_algo),
        .i_intt    (i_intt),
        .i_skip    (i_skip),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_twiddle (i_twiddle),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_a       (o_a),
        .o_b       (o_b)
    );

    always #5 clk = ~clk;

    function automatic longint ref_q(bit algo);
        return algo ? 64'sd8380417 : 64'sd3329;
    endfunction

    // Montgomery reduction by definition: m is the centred residue of x*qinv mod R.
    function automatic longint ref_mont(longint x, bit algo);
        longint q, r, qinv, m;
        q    = ref_q(algo);
        r    = algo ? 64'sd4294967296 : 64'sd65536;
        qinv = algo ? 64'sd58728449 : -64'sd3327;
        m    = ((x % r) * qinv) % r;
        if (m < 0) m += r;
        if (m >= r / 2) m -= r;
        return (x - m * q) / r;
    endfunction

    function automatic exp_t ref_beat(bit algo, bit intt, bit skip,
                                      logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] tw);
        exp_t   e;
        longint q, av, bv, tv, t, s, oa, ob;
        q = ref_q(algo);
        for (int k = 0; k < LANES; k++) begin
            av = longint'($signed(a[32*k +: 32]));
            bv = longint'($signed(b[32*k +: 32]));
            tv = longint'($signed(tw[32*k +: 32]));
            if (skip) begin
                oa = av;
                ob = bv;
            end else if (!intt) begin
                t  = ref_mont(bv * tv, algo);
                oa = av + t;
                ob = av - t;
            end else begin
                s = av + bv;
                if (!algo) begin
                    if (s >= q) s -= q;
                    if (s <= -q) s += q;
                end
                oa = s;
                ob = ref_mont((bv - av) * tv, algo);
            end
`ifdef BFU_CANON_EN
            if (!skip) begin
                oa = ((oa % q) + q) % q;
                ob = ((ob % q) + q) % q;
            end
`endif
            e.ea[32*k +: 32] = oa[31:0];
            e.eb[32*k +: 32] = ob[31:0];
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rand_beat(bit algo, bit intt, bit skip);
        int q;
        q      = algo ? 8380417 : 3329;
        i_algo = algo;
        i_intt = intt;
        i_skip = skip;
        for (int k = 0; k < LANES; k++) begin
            i_a[32*k +: 32]       = int'($urandom_range(2*q - 2)) - (q - 1);
            i_b[32*k +: 32]       = int'($urandom_range(2*q - 2)) - (q - 1);
            i_twiddle[32*k +: 32] = int'($urandom_range(2*q - 2)) - (q - 1);
        end
    endtask

    task automatic rand_mode_beat();
        rand_beat(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(3) == 0));
    endtask

    task automatic fixed_beat(bit algo, bit intt, int a, int b, int tw);
        i_algo = algo;
        i_intt = intt;
        i_skip = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            i_a[32*k +: 32]       = a;
            i_b[32*k +: 32]       = b;
            i_twiddle[32*k +: 32] = tw;
        end
    endtask

    // One clock: settle, score the drain and the accept of this cycle, then step.
    task automatic tick(output bit acc);
        bit   drn;
        exp_t e;
        #1;
        acc = i_valid && o_ready;
        drn = o_valid && i_ready;
        if (drn) begin
            checks++;
            assert (sbq.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed=extra_beat expected=no_beat");
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_oa", o_a, e.ea);
                chk("sb_ob", o_b, e.eb);
            end
        end
        if (acc) sbq.push_back(ref_beat(i_algo, i_intt, i_skip, i_a, i_b, i_twiddle));
        @(posedge clk);
        #1;
    endtask

    // Send the prepared beat alone and check the clock count to o_valid
    // (the accept edge counts as the first).
    task automatic send_one_and_wait(string tag);
        int n;
        bit acc;
        i_valid = 1'b1;
        i_ready = 1'b1;
        tick(acc);
        i_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 20) begin
            tick(acc);
            n++;
        end
        chk({tag, "_latency"}, W'(n), W'(LAT));
    endtask

    task automatic drain(string tag);
        bit acc;
        int n;
        n       = 0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        while (sbq.size() != 0 && n < 60) begin
            tick(acc);
            n++;
        end
        chk(tag, W'(sbq.size()), W'(0));
    endtask

    initial begin
        bit           acc;
        int           n, sent, obk;
        logic [W-1:0] sa, sb, snap_a, snap_b;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ovalid", W'(o_valid), W'(0));
        chk("rst_oa", o_a, '0);
        chk("rst_ob", o_b, '0);
        rst_n = 1'b1;
        #1;
        chk("rst_oready", W'(o_ready), W'(1));

        // Kyber NTT, twiddle = R mod q so t = b
        fixed_beat(1'b0, 1'b0, 100, 5, 2285);
        send_one_and_wait("k_ntt");
        chk("k_ntt_oa", o_a, {LANES{32'd105}});
        chk("k_ntt_ob", o_b, {LANES{32'd95}});
        drain("k_ntt_drain");

        // Kyber INTT with the a+b >= q correction
        fixed_beat(1'b0, 1'b1, 3000, 1000, 2285);
        send_one_and_wait("k_intt");
        chk("k_intt_oa", o_a, {LANES{32'd671}});
        for (int k = 0; k < LANES; k++) begin
            obk = $signed(o_b[32*k +: 32]);
            chk("k_intt_ob_cong", W'((obk + 2000) % 3329 == 0), W'(1));
            chk("k_intt_ob_range", W'(obk > -3329 && obk < 3329), W'(1));
        end
        drain("k_intt_drain");

        // Dilithium NTT, twiddle = 2^32 mod q
        fixed_beat(1'b1, 1'b0, 10, 1, 4193792);
        send_one_and_wait("d_ntt");
`ifdef BFU_CANON_EN
        chk("d_ntt_oa", o_a, {LANES{32'd11}});
        chk("d_ntt_ob", o_b, {LANES{32'd9}});
`endif
        drain("d_ntt_drain");

        // Skip beat between two butterflies of different algorithms, no bubbles
        i_ready = 1'b1;
        i_valid = 1'b1;
        rand_beat(1'b0, 1'b0, 1'b0);
        tick(acc);
        rand_beat(1'b1, 1'b0, 1'b1);
        sa = i_a;
        sb = i_b;
        tick(acc);
        rand_beat(1'b1, 1'b1, 1'b0);
        tick(acc);
        i_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 20) begin
            tick(acc);
            n++;
        end
        chk("skip_first_valid", W'(o_valid), W'(1));
        tick(acc);
        chk("skip_no_bubble", W'(o_valid), W'(1));
        chk("skip_oa_exact", o_a, sa);
        chk("skip_ob_exact", o_b, sb);
        tick(acc);
        chk("skip_next_no_bubble", W'(o_valid), W'(1));
        drain("skip_drain");

        // Stall: 8 beats streamed, downstream holds off for 3 cycles
        sent = 0;
        rand_mode_beat();
        for (int c = 0; c < 16; c++) begin
            i_ready = !(c >= 7 && c < 10);
            i_valid = (sent < 8);
            #1;
            if (c == 7) begin
                snap_a = o_a;
                snap_b = o_b;
                chk("stall_ovalid", W'(o_valid), W'(1));
            end
            if (c >= 8 && c <= 10) begin
                chk("stall_oa_hold", o_a, snap_a);
                chk("stall_ob_hold", o_b, snap_b);
                chk("stall_ovalid_hold", W'(o_valid), W'(1));
            end
            if (c >= 7 && c < 10) chk("stall_oready", W'(o_ready), W'(0));
            tick(acc);
            if (acc) begin
                sent++;
                rand_mode_beat();
            end
        end
        chk("stall_sent", W'(sent), W'(8));
        drain("stall_drain");

        // Randomized traffic with random valid and ready
        i_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!i_valid && $urandom_range(3) != 0) begin
                rand_mode_beat();
                i_valid = 1'b1;
            end
            i_ready = ($urandom_range(3) != 0);
            tick(acc);
            if (acc) i_valid = 1'b0;
        end
        drain("rand_drain");

        // Reset with 4 beats in flight and the first one held at the output
        i_ready = 1'b1;
        i_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            rand_mode_beat();
            tick(acc);
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        n = 0;
        while (!o_valid && n < 20) begin
            tick(acc);
            n++;
        end
        chk("rstmid_pre_ovalid", W'(o_valid), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_ovalid", W'(o_valid), W'(0));
        chk("rstmid_oa", o_a, '0);
        chk("rstmid_ob", o_b, '0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        i_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick(acc);
            chk("rstmid_after_ovalid", W'(o_valid), W'(0));
        end
        fixed_beat(1'b0, 1'b0, 100, 5, 2285);
        send_one_and_wait("post_rst");
        chk("post_rst_oa", o_a, {LANES{32'd105}});
        drain("post_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bfu_lanes.md
# bfu_lanes

Parametrised multi-lane butterfly array for the shared Kyber/Dilithium NTT datapath. It runs LANES Cooley-Tukey (NTT) or Gentleman-Sande (INTT) butterflies per beat with Montgomery reduction of the twiddle product. Unlike the single-lane BFU, it takes per-beat mode tags and uses a valid/ready handshake with full-pipeline stall. It sits between the coefficient-memory read crossbar and the write-back crossbar.

## Interface
- LANES, 4: butterflies per beat (1..8)
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  input beat accepted when i_valid && o_ready
- i_algo  in  1  0 = Kyber (q=3329), 1 = Dilithium (q=8380417); per beat
- i_intt  in  1  0 = NTT butterfly, 1 = INTT butterfly; per beat
- i_skip  in  1  pass a/b through unchanged; per beat
- i_a, i_b, i_twiddle  in  LANES×32 signed  per-lane operands; lane k in bits [32k+31:32k]
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts when o_valid && i_ready
- o_a, o_b  out  LANES×32 signed  per-lane results

## Operation
- Input contract: i_a, i_b in (-q,q); i_twiddle is a Montgomery-domain constant (R=2^16 Kyber, 2^32 Dilithium).
- Mont(x): Dilithium: m = low32(x·58728449), r = (x − m·q) >>> 32. Kyber: m = sext(low16(x·(−3327))), r = (x − m·q) >>> 16. Products are 64-bit signed; r lies in (−q,q).
- NTT: t = Mont(b·tw); o_a = a+t; o_b = a−t.
- INTT: s = a+b; d = b−a; o_a = s; o_b = Mont(d·tw). Kyber only: s ≥ q → s−q, then s ≤ −q → s+q (two stages).
- Skip: o_a = a, o_b = b; same latency as the other modes.
- Mode tags (algo, intt, skip) are captured with the beat and travel down the pipeline. Different beats may use different modes back-to-back; there is no bubble on a mode change.
- All lanes share one valid/stall; lanes never diverge in time.

## Timing
- Pipeline: S0 input register, S1 multiply, S2 QINV multiply, S3 reduction subtract/shift, S4 add/sub into output register.
- Latency: 5 cycles from the accept edge to o_valid without the macro, 6 with it. Throughput is one beat per cycle.
- Stall: advance = !o_valid || i_ready; o_ready = advance. When advance=0, every stage register and per-stage valid holds.
- Bubbles: per-stage valid bits; invalid beats flow through and never raise o_valid.
- o_a/o_b remain stable while o_valid && !i_ready.
- Reset: all stage valids and o_valid = 0; o_a = o_b = 0; o_ready = 1 after reset.
- Reset mid-operation discards all in-flight beats; no partial beat appears after reset release.
- Simultaneous accept-in and drain-out in one cycle is legal with no bubble.

## Configuration
- BFU_CANON_EN defined:
  - adds stage S5, which maps o_a and o_b per lane into [0,q);
  - mapping: if r<0 then r += 2q; then if r ≥ q then r −= q;
  - latency becomes 6.
- Undefined: outputs are uncorrected in (−2q,2q); latency is 5.

## Structure
- Package bfu_pkg:
  - KYBER_Q, KYBER_QINV, DILITHIUM_Q, DILITHIUM_QINV;
  - WORD_W=32;
  - packed struct bfu_tag_t {algo, intt, skip};
  - function mont_reduce(prod64, algo).
- Sub-module bfu_lane: the single-lane datapath (S0–S4/S5 data registers) driven by a shared advance signal and a shared tag pipeline.
- The top level instantiates LANES copies and owns the valid/tag pipeline and the handshake.

## Test plan
- Kyber NTT, all lanes a=100, b=5, tw=2285, i_ready=1 → 5 cycles later o_a=105, o_b=95 in every lane.
- Dilithium NTT with BFU_CANON_EN, a=10, b=1, tw=4193792 → o_a=11, o_b=9 after 6 cycles.
- Kyber INTT, a=3000, b=1000, tw=2285 → o_a=671 (4000−3329), o_b ≡ −2000 mod 3329.
- Skip beat interleaved between NTT beats with random values → skip outputs equal the inputs exactly; neighbouring beats are unaffected; no bubbles.
- Stall: stream 8 beats and hold i_ready=0 for 3 cycles mid-stream → o_a/o_b stay stable, o_ready=0 while stalled, no beat lost or duplicated, order preserved.
- Assert i_rst_n=0 for 1 cycle with 4 beats in flight → o_valid=0 and outputs=0 immediately; o_valid stays 0 after release until a new beat arrives.
